// File: rtl/txfifo_sc_pkt_pkg.sv
// Shared sizing helpers for the single-clock packet TX FIFO.
// Pointers carry one extra wrap bit; each entry stores {eop, data}.
package txfifo_sc_pkt_pkg;

  function automatic int ptr_w(input int ptr);
    return ptr + 1;
  endfunction

  function automatic int entry_w(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/txfifo_sc_pkt_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register clears on reset/flush and holds when not reading.
module txfifo_sc_pkt_sdp_ram #(
  parameter int AW = 10,
  parameter int DW = 65
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          i_clr,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)    o_rdata <= '0;
    else if (i_clr) o_rdata <= '0;
    else if (i_re)  o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/txfifo_sc_pkt.sv
// Single-clock TX FIFO with store-and-forward packet mode: the reader only
// sees committed packets; the writer can abort the packet it is building.
module txfifo_sc_pkt
  import txfifo_sc_pkt_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int PTR      = 10,
  parameter int AFULL_TH = 1000,
  parameter int PKT_MODE = 1
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             sclr,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  input  logic             wreop,
  input  logic             wrabort,
  output logic             wrfull,
  output logic             wralmfull,
  output logic [PTR:0]     wrusedw,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             rdeop,
  output logic             rdempty,
  output logic [PTR:0]     pktcnt,
  output logic             ovf,
  output logic             udf
);

  localparam int PW    = ptr_w(PTR);
  localparam int EW    = entry_w(WIDTH);
  localparam int DEPTH = 2**PTR;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_C = PW'(AFULL_TH);
  localparam logic [PW-1:0] ONE_C   = PW'(1);

  logic [PW-1:0]    r_wr_ptr, r_cm_ptr, r_rd_ptr, r_pktcnt, r_wrusedw;
  logic             r_wrfull, r_wralmfull, r_rdempty, r_ovf, r_udf;
  logic [DEPTH-1:0] r_eop_vec;

  logic             w_wr_acc, w_rd_acc, w_abort, w_commit, w_rd_eop;
  logic [PW-1:0]    w_wr_nxt, w_cm_nxt, w_rd_nxt, w_used_nxt, w_pkt_nxt;
  logic [EW-1:0]    w_rdout;

  // Flags are those of the current cycle: a same-cycle read never frees a slot.
  assign w_wr_acc = wrreq & ~r_wrfull;
  assign w_rd_acc = rdreq & ~r_rdempty;
  assign w_abort  = (PKT_MODE != 0) & wrabort;
  assign w_commit = w_wr_acc & wreop & ~w_abort;
  assign w_rd_eop = r_eop_vec[r_rd_ptr[PTR-1:0]];

  always_comb begin
    w_wr_nxt = r_wr_ptr;
    if (w_abort)       w_wr_nxt = r_cm_ptr;
    else if (w_wr_acc) w_wr_nxt = r_wr_ptr + ONE_C;

    w_cm_nxt = r_cm_ptr;
    if (w_commit || (PKT_MODE == 0 && w_wr_acc)) w_cm_nxt = r_wr_ptr + ONE_C;

    w_rd_nxt   = w_rd_acc ? r_rd_ptr + ONE_C : r_rd_ptr;
    w_used_nxt = w_wr_nxt - w_rd_nxt;

    w_pkt_nxt = r_pktcnt;
    case ({w_commit, w_rd_acc & w_rd_eop})
      2'b10:   w_pkt_nxt = r_pktcnt + ONE_C;
      2'b01:   w_pkt_nxt = r_pktcnt - ONE_C;
      default: w_pkt_nxt = r_pktcnt;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_wr_ptr    <= '0;
      r_cm_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_pktcnt    <= '0;
      r_wrusedw   <= '0;
      r_wrfull    <= 1'b0;
      r_wralmfull <= 1'b0;
      r_rdempty   <= 1'b1;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else if (sclr) begin
      r_wr_ptr    <= '0;
      r_cm_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_pktcnt    <= '0;
      r_wrusedw   <= '0;
      r_wrfull    <= 1'b0;
      r_wralmfull <= 1'b0;
      r_rdempty   <= 1'b1;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_nxt;
      r_cm_ptr    <= w_cm_nxt;
      r_rd_ptr    <= w_rd_nxt;
      r_pktcnt    <= w_pkt_nxt;
      r_wrusedw   <= w_used_nxt;
      r_wrfull    <= (w_used_nxt == DEPTH_C);
      r_wralmfull <= (w_used_nxt >= AFULL_C);
      r_rdempty   <= (w_cm_nxt == w_rd_nxt);
      if (wrreq & r_wrfull)  r_ovf <= 1'b1;
      if (rdreq & r_rdempty) r_udf <= 1'b1;
    end
  end

  // Flop copy of the eop bits so pktcnt can decrement in the same cycle as the read.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_eop_vec[r_wr_ptr[PTR-1:0]] <= wreop;
  end

  txfifo_sc_pkt_sdp_ram #(.AW(PTR), .DW(EW)) u_ram (
    .clk     (clk),
    .reset_  (reset_),
    .i_clr   (sclr),
    .i_we    (w_wr_acc & ~sclr),
    .i_waddr (r_wr_ptr[PTR-1:0]),
    .i_wdata ({wreop, data}),
    .i_re    (w_rd_acc & ~sclr),
    .i_raddr (r_rd_ptr[PTR-1:0]),
    .o_rdata (w_rdout)
  );

  assign q         = w_rdout[WIDTH-1:0];
  assign rdeop     = w_rdout[WIDTH];
  assign wrfull    = r_wrfull;
  assign wralmfull = r_wralmfull;
  assign wrusedw   = r_wrusedw;
  assign rdempty   = r_rdempty;
  assign pktcnt    = r_pktcnt;
  assign ovf       = r_ovf;
  assign udf       = r_udf;

endmodule
